// File: rtl/fc8_timer_sfr_array.sv
// rtl/fc8_timer_sfr_array.sv - multi-channel prescaled down-counting timer SFR block
module fc8_timer_sfr_array #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 16,
  parameter int          PRESC_W   = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sfr_cs_in,
  input  logic              sfr_wr_en_in,
  input  logic              sfr_rd_en_in,
  input  logic [15:0]       sfr_addr_in,
  input  logic [7:0]        sfr_data_in,
  output logic [7:0]        sfr_data_out,
  output logic              timer_irq_out,
  output logic [NUM_CH-1:0] timer_pending_out,
  output logic [NUM_CH-1:0] timer_tick_out
);

  logic                freeze;
  logic [NUM_CH-1:0]   status;
  logic [NUM_CH-1:0]   en;
  logic [NUM_CH-1:0]   mode;
  logic [NUM_CH-1:0]   ie;
  logic [NUM_CH-1:0]   tick_q;
  logic                irq_q;
  logic [PRESC_W-1:0]  presc           [NUM_CH];
  logic [PRESC_W-1:0]  presc_cnt       [NUM_CH];
  logic [CNT_W-1:0]    count           [NUM_CH];
  logic [CNT_W-1:0]    reload          [NUM_CH];
  logic [7:0]          reload_lo_stage [NUM_CH];
  logic [7:0]          count_hi_shadow [NUM_CH];
  logic [15:0]         count_ext       [NUM_CH];
  logic [15:0]         reload_ext      [NUM_CH];

  logic [NUM_CH-1:0]   ch_sel;
  logic [NUM_CH-1:0]   ctrl_wr;
  logic [NUM_CH-1:0]   load;
  logic [NUM_CH-1:0]   tick_ev;
  logic [NUM_CH-1:0]   expire;
  logic [NUM_CH-1:0]   w1c_mask;

  // Address decode: offsets below BASE_ADDR never select anything.
  logic [15:0] off;
  logic [12:0] blk;
  logic        in_blk;
  logic        wr_acc;
  logic        rd_acc;
  logic        glb_wr;

  assign off    = sfr_addr_in - BASE_ADDR;
  assign blk    = off[15:3];
  assign in_blk = sfr_cs_in && (sfr_addr_in >= BASE_ADDR);
  assign wr_acc = in_blk && sfr_wr_en_in;
  assign rd_acc = in_blk && sfr_rd_en_in && !sfr_wr_en_in;
  assign glb_wr = wr_acc && (blk == 13'd0);

  assign w1c_mask = (glb_wr && off[2:0] == 3'd1) ? sfr_data_in[NUM_CH-1:0] : '0;

  // Per-channel strobes: a load event suppresses that cycle's tick so reload always wins.
  always_comb begin
    ch_sel  = '0;
    ctrl_wr = '0;
    load    = '0;
    tick_ev = '0;
    expire  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_ext[i]  = 16'(count[i]);
      reload_ext[i] = 16'(reload[i]);
      ch_sel[i]  = in_blk && (blk == 13'(i + 1));
      ctrl_wr[i] = wr_acc && ch_sel[i] && (off[2:0] == 3'd0);
      load[i]    = (ctrl_wr[i] && (sfr_data_in[3] || (sfr_data_in[0] && !en[i]))) ||
                   (glb_wr && (off[2:0] == 3'd2) && sfr_data_in[i]);
      tick_ev[i] = en[i] && !freeze && (presc_cnt[i] >= presc[i]) && !load[i];
      expire[i]  = tick_ev[i] && (count[i] == '0);
    end
  end

  // Channel state: prescaler, counter, control bits, reload staging and count shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= '0;
      mode <= '0;
      ie   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        presc[i]           <= '0;
        presc_cnt[i]       <= '0;
        count[i]           <= '0;
        reload[i]          <= '0;
        reload_lo_stage[i] <= '0;
        count_hi_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load[i]) begin
          presc_cnt[i] <= '0;
        end else if (en[i] && !freeze) begin
          presc_cnt[i] <= (presc_cnt[i] >= presc[i]) ? '0 : presc_cnt[i] + 1'b1;
        end

        if (load[i]) begin
          count[i] <= reload[i];
        end else if (tick_ev[i]) begin
          if (count[i] != '0) count[i] <= count[i] - 1'b1;
          else                count[i] <= mode[i] ? '0 : reload[i];
        end

        if (ctrl_wr[i]) begin
          en[i]   <= sfr_data_in[0];
          mode[i] <= sfr_data_in[1];
          ie[i]   <= sfr_data_in[2];
        end else if (expire[i] && mode[i]) begin
          en[i] <= 1'b0;
        end

        if (wr_acc && ch_sel[i]) begin
          case (off[2:0])
            3'd1:    presc[i]           <= sfr_data_in[PRESC_W-1:0];
            3'd2:    reload_lo_stage[i] <= sfr_data_in;
            3'd3:    reload[i]          <= CNT_W'({sfr_data_in, reload_lo_stage[i]});
            default: ;
          endcase
        end

        if (rd_acc && ch_sel[i] && (off[2:0] == 3'd4)) begin
          count_hi_shadow[i] <= count_ext[i][15:8];
        end
      end
    end
  end

  // Global state: freeze, W1C status (expiry set beats clear), tick pulse and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      freeze <= 1'b0;
      status <= '0;
      tick_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (glb_wr && off[2:0] == 3'd0) freeze <= sfr_data_in[0];
      status <= (status & ~w1c_mask) | expire;
      tick_q <= expire;
      irq_q  <= |(status & ie);
    end
  end

  assign timer_irq_out     = irq_q;
  assign timer_pending_out = status;
  assign timer_tick_out    = tick_q;

  // Combinational read mux; unmapped offsets and deselected cycles return 0.
  always_comb begin
    sfr_data_out = '0;
    if (in_blk) begin
      if (blk == 13'd0) begin
        case (off[2:0])
          3'd0:    sfr_data_out = {7'd0, freeze};
          3'd1:    sfr_data_out = 8'(status);
          3'd3:    sfr_data_out = 8'(NUM_CH);
          default: sfr_data_out = '0;
        endcase
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel[i]) begin
          case (off[2:0])
            3'd0:    sfr_data_out = {5'd0, ie[i], mode[i], en[i]};
            3'd1:    sfr_data_out = 8'(presc[i]);
            3'd2:    sfr_data_out = reload_ext[i][7:0];
            3'd3:    sfr_data_out = reload_ext[i][15:8];
            3'd4:    sfr_data_out = count_ext[i][7:0];
            3'd5:    sfr_data_out = count_hi_shadow[i];
            default: sfr_data_out = '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fc8_timer_sfr_array.sv
// tb/tb_fc8_timer_sfr_array.sv - self-checking bench for fc8_timer_sfr_array
module tb_fc8_timer_sfr_array;

  localparam logic [15:0] BASE   = 16'h0100;
  localparam logic [15:0] GCTRL  = BASE;
  localparam logic [15:0] STATUS = BASE + 16'd1;
  localparam logic [15:0] SYNC   = BASE + 16'd2;
  localparam logic [15:0] ID     = BASE + 16'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        irq;
  logic [3:0]  pend;
  logic [3:0]  tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fc8_timer_sfr_array #(
    .NUM_CH(4), .CNT_W(16), .PRESC_W(8), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .sfr_cs_in(cs), .sfr_wr_en_in(wr), .sfr_rd_en_in(rd),
    .sfr_addr_in(addr), .sfr_data_in(din), .sfr_data_out(dout),
    .timer_irq_out(irq), .timer_pending_out(pend), .timer_tick_out(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ra(input int ch, input int r);
    return BASE + 16'(8 + 8 * ch + r);
  endfunction

  task automatic sfr_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1; wr = 1; rd = 0; addr = a; din = d;
    @(negedge clk); cs = 0; wr = 0;
  endtask

  task automatic write_at(input int edge_n, input logic [15:0] a, input logic [7:0] d);
    while (cyc < edge_n - 1) @(negedge clk);
    cs = 1; wr = 1; rd = 0; addr = a; din = d;
    @(negedge clk); cs = 0; wr = 0;
  endtask

  task automatic sfr_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1; rd = 1; wr = 0; addr = a;
    #1 d = dout;
    @(negedge clk); cs = 0; rd = 0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [7:0] d);
    cs = 1; rd = 0; wr = 0; addr = a;
    #1 d = dout;
    cs = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  task automatic wait_tick(input int ch, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (tick[ch]) begin at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    checks++; if (tick !== 4'h0) begin errors++; $display("FAIL reset_tick got %h exp 0", tick); end
    checks++; if (pend !== 4'h0) begin errors++; $display("FAIL reset_pend got %h exp 0", pend); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    peek(ID, d);
    checks++; if (d !== 8'd4) begin errors++; $display("FAIL reset_id got %h exp 04", d); end
    peek(ra(0, 0), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", d); end
    sfr_write(BASE + 16'h28, 8'hFF);
    peek(BASE + 16'h28, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h exp 00", d); end
  endtask

  task automatic test_auto_reload();
    int t0, t1, t2;
    do_reset();
    sfr_write(ra(0, 1), 8'd3); sfr_write(ra(0, 2), 8'd4); sfr_write(ra(0, 3), 8'd0);
    sfr_write(ra(0, 0), 8'h05); t0 = cyc;
    wait_tick(0, 40, t1);
    checks++; if (t1 != t0 + 20) begin errors++; $display("FAIL auto_first got %0d exp %0d", t1 - t0, 20); end
    checks++; if (pend !== 4'h1) begin errors++; $display("FAIL auto_pend got %h exp 1", pend); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL auto_irq_lag got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL auto_irq got %b exp 1", irq); end
    checks++; if (tick !== 4'h0) begin errors++; $display("FAIL auto_pulse_width got %h exp 0", tick); end
    wait_tick(0, 40, t2);
    checks++; if (t2 != t1 + 20) begin errors++; $display("FAIL auto_period got %0d exp 20", t2 - t1); end
    sfr_write(STATUS, 8'h01);
    checks++; if (pend !== 4'h0) begin errors++; $display("FAIL w1c_clear got %h exp 0", pend); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_hold got %b exp 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop got %b exp 0", irq); end
    sfr_write(ra(0, 0), 8'h00);
  endtask

  task automatic test_one_shot();
    int t0, t;
    int extra;
    logic [7:0] d;
    do_reset();
    sfr_write(ra(1, 1), 8'd0); sfr_write(ra(1, 2), 8'd2); sfr_write(ra(1, 3), 8'd0);
    sfr_write(ra(1, 0), 8'h03); t0 = cyc;
    wait_tick(1, 10, t);
    checks++; if (t != t0 + 3) begin errors++; $display("FAIL oneshot_time got %0d exp 3", t - t0); end
    peek(ra(1, 0), d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL oneshot_ctrl got %h exp 02", d); end
    sfr_read(ra(1, 4), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL oneshot_count got %h exp 00", d); end
    extra = 0;
    repeat (20) begin @(negedge clk); if (tick[1]) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL oneshot_extra got %0d exp 0", extra); end
    checks++; if (pend !== 4'h2) begin errors++; $display("FAIL oneshot_pend got %h exp 2", pend); end
  endtask

  task automatic test_w1c_race();
    int t0;
    logic [7:0] d;
    do_reset();
    sfr_write(ra(0, 1), 8'd3); sfr_write(ra(0, 2), 8'd4); sfr_write(ra(0, 3), 8'd0);
    sfr_write(ra(0, 0), 8'h05); t0 = cyc;
    write_at(t0 + 25, STATUS, 8'h01);
    checks++; if (pend !== 4'h0) begin errors++; $display("FAIL race_preclear got %h exp 0", pend); end
    write_at(t0 + 40, STATUS, 8'h01);
    checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL race_tick got %b exp 1", tick[0]); end
    checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL race_set_wins got %b exp 1", pend[0]); end
    peek(STATUS, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL race_status got %h exp 01", d); end
    sfr_write(ra(0, 0), 8'h00);
  endtask

  task automatic test_atomic_read();
    int t0;
    logic [7:0] d;
    do_reset();
    sfr_write(ra(2, 1), 8'd7); sfr_write(ra(2, 2), 8'h00); sfr_write(ra(2, 3), 8'h01);
    sfr_write(ra(2, 0), 8'h01); t0 = cyc;
    sfr_read(ra(2, 4), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL atomic_lo got %h exp 00", d); end
    while (cyc < t0 + 9) @(negedge clk);
    sfr_read(ra(2, 5), d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL atomic_hi got %h exp 01", d); end
    sfr_read(ra(2, 4), d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL atomic_lo2 got %h exp ff", d); end
    sfr_read(ra(2, 5), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL atomic_hi2 got %h exp 00", d); end
  endtask

  task automatic test_sync_freeze();
    int ts;
    int bad;
    logic [7:0] a0, a2, b0;
    do_reset();
    sfr_write(ra(0, 1), 8'd1); sfr_write(ra(0, 2), 8'd3); sfr_write(ra(0, 3), 8'd0);
    sfr_write(ra(0, 0), 8'h01);
    @(negedge clk);
    sfr_write(ra(2, 1), 8'd1); sfr_write(ra(2, 2), 8'd3); sfr_write(ra(2, 3), 8'd0);
    sfr_write(ra(2, 0), 8'h01);
    sfr_write(SYNC, 8'h05); ts = cyc;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tick[0] !== tick[2] || tick[0] !== (((cyc - ts) % 8) == 0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL sync_align got %0d bad cycles exp 0", bad); end
    sfr_write(GCTRL, 8'h01);
    sfr_read(ra(0, 4), a0);
    sfr_read(ra(2, 4), a2);
    bad = 0;
    repeat (10) begin @(negedge clk); if (tick !== 4'h0) bad++; end
    sfr_read(ra(0, 4), b0);
    checks++; if (b0 !== a0) begin errors++; $display("FAIL freeze_hold got %h exp %h", b0, a0); end
    checks++; if (a2 !== a0) begin errors++; $display("FAIL freeze_sync got %h exp %h", a2, a0); end
    checks++; if (bad != 0) begin errors++; $display("FAIL freeze_ticks got %0d exp 0", bad); end
    sfr_write(GCTRL, 8'h00);
    sfr_write(ra(0, 0), 8'h00); sfr_write(ra(2, 0), 8'h00);
  endtask

  task automatic test_random_periods();
    int t0[4], per[4];
    bit md[4], alive[4];
    logic [3:0] iev, exp_tick, exp_pend, clr;
    logic exp_irq;
    logic [7:0] d;
    int pm, rl, e, c, r, bad;
    do_reset();
    sfr_write(GCTRL, 8'h01);
    iev = 4'(($urandom));
    for (int i = 0; i < 4; i++) begin
      pm = $urandom_range(0, 3);
      rl = $urandom_range(0, 6);
      md[i] = ($urandom_range(0, 2) == 0);
      per[i] = (rl + 1) * (pm + 1);
      sfr_write(ra(i, 1), 8'(pm));
      sfr_write(ra(i, 2), 8'(rl));
      sfr_write(ra(i, 3), 8'h00);
      sfr_write(ra(i, 0), {5'd0, iev[i], md[i], 1'b1});
    end
    sfr_write(GCTRL, 8'h00);
    for (int i = 0; i < 4; i++) begin t0[i] = cyc; alive[i] = 1; end
    exp_pend = '0; clr = '0; bad = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      e = cyc;
      exp_tick = '0;
      for (int i = 0; i < 4; i++) begin
        if (alive[i] && e > t0[i] && ((e - t0[i]) % per[i]) == 0) begin
          exp_tick[i] = 1'b1;
          if (md[i]) alive[i] = 0;
        end
      end
      exp_irq = |(exp_pend & iev);
      exp_pend = (exp_pend & ~clr) | exp_tick;
      clr = '0;
      checks++;
      if (tick !== exp_tick || pend !== exp_pend || irq !== exp_irq) begin
        errors++;
        $display("FAIL rand_cycle %0d got tick %h pend %h irq %b exp tick %h pend %h irq %b",
                 e, tick, pend, irq, exp_tick, exp_pend, exp_irq);
      end
      cs = 0; wr = 0;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        c = $urandom_range(0, 3);
        cs = 1; wr = 1; addr = ra(c, 0); din = {4'h0, 1'b1, iev[c], md[c], 1'b1};
        t0[c] = e + 1; alive[c] = 1;
      end else if (r == 1) begin
        clr = 4'($urandom);
        cs = 1; wr = 1; addr = STATUS; din = {4'h0, clr};
      end
    end
    @(negedge clk); cs = 0; wr = 0;
    for (int i = 0; i < 4; i++) begin
      peek(ra(i, 0), d);
      if (d[0] !== (md[i] ? alive[i] : 1'b1)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_en_state got %0d bad channels exp 0", bad); end
    for (int i = 0; i < 4; i++) sfr_write(ra(i, 0), 8'h00);
  endtask

  task automatic test_rst_mid();
    logic [7:0] d;
    do_reset();
    sfr_write(ra(0, 1), 8'd0); sfr_write(ra(0, 2), 8'd0); sfr_write(ra(0, 3), 8'd0);
    sfr_write(ra(0, 0), 8'h05);
    repeat (3) @(negedge clk);
    checks++; if (pend[0] !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL rst_pre got pend %h irq %b exp 1 1", pend, irq); end
    do_reset();
    checks++; if (tick !== 4'h0) begin errors++; $display("FAIL rst_tick got %h exp 0", tick); end
    checks++; if (pend !== 4'h0) begin errors++; $display("FAIL rst_pend got %h exp 0", pend); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    peek(ID, d);
    checks++; if (d !== 8'd4) begin errors++; $display("FAIL rst_id got %h exp 04", d); end
    peek(ra(0, 0), d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_ctrl got %h exp 00", d); end
  endtask

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_w1c_race();
    test_atomic_read();
    test_sync_freeze();
    test_random_periods();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
